// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the Execute-stage divide unit.
//   div_state_e   - divider FSM states (IDLE, BUSY, DONE)
//   WIDTH_DEF     - default operand / result width
//   REG_W_DEF     - default destination register index width
//   DBZ_QUOT_BIT  - fill bit of the quotient reported on divide-by-zero
package ex_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int REG_W_DEF = 8;

    // Divide-by-zero quotient is all ones; replicated to the instance width.
    localparam logic DBZ_QUOT_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : ex_pkg

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i   - partial remainder from the previous step (always < divisor_i)
//   bit_i   - next dividend bit, MSB first
//   divisor_i - divisor
//   rem_o   - new partial remainder
//   qbit_o  - quotient bit produced by this step
module div_step
    import ex_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Shift in the next dividend bit and trial-subtract; the extra top bit of
    // diff_s is the borrow, so the WIDTH+1-bit trial never overflows.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        diff_s    = {1'b0, shifted_s} - {2'b00, divisor_i};
        qbit_o    = ~diff_s[WIDTH+1];
        if (qbit_o) begin
            rem_o = diff_s[WIDTH-1:0];
        end else begin
            rem_o = shifted_s[WIDTH-1:0];
        end
    end

endmodule : div_step

// File: rtl/ex_div_stall.sv
// ex_div_stall: multi-cycle unsigned restoring divider in the Execute stage.
// Sits behind the Decode-to-Execute register and freezes it (stall) while a
// divide iterates, then releases it for exactly one result cycle (DONE).
//   clk, rst_n          - clock, asynchronous active-low reset
//   div_i               - divide flag from the pipeline register
//   data_a_i, data_b_i  - dividend, divisor
//   dest_i              - destination register index
//   stall               - freeze request (combinational, Mealy)
//   done_o              - one-cycle result strobe
//   quot_o, rem_o       - quotient, remainder (held until next result)
//   dest_o              - captured destination for write-back
//   dbz_o               - divide-by-zero flag, qualified by done_o
module ex_div_stall
    import ex_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic [WIDTH-1:0] data_b_i,
    input  logic [REG_W-1:0] dest_i,
    output logic             stall,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic [REG_W-1:0] dest_o,
    output logic             dbz_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] wquot_q, wquot_d;
    logic [REG_W-1:0] wdest_q, wdest_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [REG_W-1:0] dest_q, dest_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_qbit_s;
    logic [WIDTH-1:0] step_quot_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dividend_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .qbit_o    (step_qbit_s)
    );

    assign step_quot_s = {wquot_q[WIDTH-2:0], step_qbit_s};

    // Freeze request: the issuing IDLE cycle plus every BUSY cycle. Gated by
    // rst_n so the pipeline is released the moment reset is asserted.
    assign stall = rst_n & (((state_q == IDLE) & div_i) | (state_q == BUSY));

    // Next-state, datapath and result-register computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        prem_d     = prem_q;
        wquot_d    = wquot_q;
        wdest_d    = wdest_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dest_d     = dest_q;
        dbz_d      = dbz_q;
        case (state_q)
            IDLE: begin
                if (div_i) begin
                    dividend_d = data_a_i;
                    divisor_d  = data_b_i;
                    wdest_d    = dest_i;
                    if (data_b_i != {WIDTH{1'b0}}) begin
                        prem_d  = {WIDTH{1'b0}};
                        wquot_d = {WIDTH{1'b0}};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = BUSY;
                    end else begin
                        // Divide-by-zero skips iteration and reports at once.
                        quot_d  = {WIDTH{DBZ_QUOT_BIT}};
                        rem_d   = data_a_i;
                        dest_d  = dest_i;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                prem_d     = step_rem_s;
                wquot_d    = step_quot_s;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last step: publish results straight from the step logic.
                    quot_d  = step_quot_s;
                    rem_d   = step_rem_s;
                    dest_d  = wdest_q;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                // div_i is still high from the frozen register; never re-issue.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            dividend_q <= {WIDTH{1'b0}};
            divisor_q  <= {WIDTH{1'b0}};
            prem_q     <= {WIDTH{1'b0}};
            wquot_q    <= {WIDTH{1'b0}};
            wdest_q    <= {REG_W{1'b0}};
            done_q     <= 1'b0;
            quot_q     <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            dest_q     <= {REG_W{1'b0}};
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            prem_q     <= prem_d;
            wquot_q    <= wquot_d;
            wdest_q    <= wdest_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dest_q     <= dest_d;
            dbz_q      <= dbz_d;
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign dest_o = dest_q;
    assign dbz_o  = dbz_q;

endmodule : ex_div_stall

// File: tb/tb_ex_div_stall.sv
// tb_ex_div_stall: scoreboard bench for ex_div_stall. Expected results are
// queued when a divide is issued and compared when done_o pulses.
module tb_ex_div_stall;

    localparam int WIDTH = 16;
    localparam int REG_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] quot;
        logic [WIDTH-1:0] rem;
        logic [REG_W-1:0] dest;
        logic             dbz;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             div_i;
    logic [WIDTH-1:0] data_a_i;
    logic [WIDTH-1:0] data_b_i;
    logic [REG_W-1:0] dest_i;
    logic             stall;
    logic             done_o;
    logic [WIDTH-1:0] quot_o;
    logic [WIDTH-1:0] rem_o;
    logic [REG_W-1:0] dest_o;
    logic             dbz_o;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    ex_div_stall #(.WIDTH(WIDTH), .REG_W(REG_W), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_i    (div_i),
        .data_a_i (data_a_i),
        .data_b_i (data_b_i),
        .dest_i   (dest_i),
        .stall    (stall),
        .done_o   (done_o),
        .quot_o   (quot_o),
        .rem_o    (rem_o),
        .dest_o   (dest_o),
        .dbz_o    (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each done pulse against the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("quot", 32'(quot_o), 32'(e.quot));
                chk("rem",  32'(rem_o),  32'(e.rem));
                chk("dest", 32'(dest_o), 32'(e.dest));
                chk("dbz",  32'(dbz_o),  32'(e.dbz));
            end
        end
    end

    // Issue one divide just after a posedge, hold div_i like a frozen pipeline
    // register, measure the stall window and release after DONE.
    task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [REG_W-1:0] d);
        exp_t e;
        int   n;
        bit   seen;
        int   exp_len;
        div_i    = 1'b1;
        data_a_i = a;
        data_b_i = b;
        dest_i   = d;
        if (b == '0) begin
            e.quot = '1;
            e.rem  = a;
            e.dbz  = 1'b1;
            exp_len = 1;
        end else begin
            e.quot = a / b;
            e.rem  = a % b;
            e.dbz  = 1'b0;
            exp_len = WIDTH + 1;
        end
        e.dest = d;
        sb_q.push_back(e);
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (stall) begin
                n++;
                chk("done_in_stall", 32'(done_o), 32'd0);
                // Already past capture: scrambled operands must be ignored.
                if (n >= 2) begin
                    data_a_i = WIDTH'($urandom);
                    data_b_i = WIDTH'($urandom);
                    dest_i   = REG_W'($urandom);
                end
            end else begin
                seen = 1'b1;
            end
        end
        if (!seen) chk("stall_timeout", 32'd0, 32'd1);
        chk("stall_len", 32'(n), 32'(exp_len));
        chk("done_pulse", 32'(done_o), 32'd1);
        @(posedge clk);
        #1;
        div_i    = 1'b0;
        data_a_i = WIDTH'($urandom);
        data_b_i = WIDTH'($urandom);
        dest_i   = REG_W'($urandom);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall),  32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_quot"},  32'(quot_o), 32'd0);
        chk({tag, "_rem"},   32'(rem_o),  32'd0);
        chk({tag, "_dest"},  32'(dest_o), 32'd0);
        chk({tag, "_dbz"},   32'(dbz_o),  32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        div_i    = 1'b0;
        data_a_i = '0;
        data_b_i = '0;
        dest_i   = '0;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_div(16'd100, 16'd7, 8'h21);
        do_div(16'h1234, 16'd0, 8'h5A);
        do_div(16'hFFFF, 16'd1, 8'h01);
        do_div(16'd5, 16'hFFFF, 8'h02);
        do_div(16'h8000, 16'h8000, 8'h03);
        for (int i = 0; i < 4; i++) begin
            do_div(WIDTH'($urandom), WIDTH'($urandom_range(65535, 1)), REG_W'($urandom));
        end

        // Back-to-back: second divide presented in the cycle right after DONE.
        do_div(16'd100, 16'd7, 8'd3);
        do_div(16'd50, 16'd6, 8'd4);
        repeat (5) begin
            @(negedge clk);
            chk("idle_after_b2b_stall", 32'(stall), 32'd0);
        end

        // Reset five cycles into a BUSY divide; the divide is abandoned.
        @(posedge clk);
        #1;
        div_i    = 1'b1;
        data_a_i = 16'd1000;
        data_b_i = 16'd3;
        dest_i   = 8'h77;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        div_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_stall", 32'(stall), 32'd0);
            chk("post_reset_done", 32'(done_o), 32'd0);
        end

        // No divide: operands toggle freely with div_i low.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            data_a_i = WIDTH'($urandom);
            data_b_i = WIDTH'($urandom);
            dest_i   = REG_W'($urandom);
            @(negedge clk);
            chk("nodiv_stall", 32'(stall), 32'd0);
            chk("nodiv_done", 32'(done_o), 32'd0);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ex_div_stall
